// File: rtl/cmd_exec_if.sv
// Command-in, result-out and local register-bus signals of the config command executor.
// master drives commands, downstream fullness and bus responses; slave is the executor itself.
interface cmd_exec_if;
    logic        command_wr;
    logic [63:0] command;
    logic        command_alf;
    logic        result_wr;
    logic [63:0] result;
    logic        result_alf;
    logic        bus_req;
    logic        bus_rw;
    logic [6:0]  bus_mdid;
    logic [19:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;
    logic [31:0] cmd_in_cnt;
    logic [31:0] result_cnt;
    logic [31:0] drop_cnt;

    modport master (
        output command_wr, command, result_alf, bus_ack, bus_rdata,
        input  command_alf, result_wr, result, bus_req, bus_rw, bus_mdid, bus_addr, bus_wdata,
        input  cmd_in_cnt, result_cnt, drop_cnt
    );

    modport slave (
        input  command_wr, command, result_alf, bus_ack, bus_rdata,
        output command_alf, result_wr, result, bus_req, bus_rw, bus_mdid, bus_addr, bus_wdata,
        output cmd_in_cnt, result_cnt, drop_cnt
    );
endinterface

// File: rtl/cmd_exec.sv
// Config command executor: buffers 64-bit commands, runs each as one register-bus access, returns results in order.
// Latency: bus request the cycle after a command lands in an idle, empty FIFO; result the cycle after ack/timeout.
// Backpressure: commands hitting a full FIFO or with bit 63 clear are dropped and counted; result_alf stalls emission.
module cmd_exec #(
    parameter int FIFO_DEPTH = 8,
    parameter int ALF_LEVEL  = 6,
    parameter int TIMEOUT    = 255
) (
    input  logic      clk_i,
    input  logic      rst_i,
    cmd_exec_if.slave ifc
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

    state_t        state_q, state_d;
    // Bit 60 of a command is reserved and replaced by the status bit, so it is not stored.
    logic [62:0]   mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q, count_d;
    logic [62:0]   cmd_q;
    logic [31:0]   rdata_q;
    logic          ok_q;
    logic [7:0]    timer_q;
    logic          alf_q;
    logic          res_wr_q;
    logic [63:0]   res_q;
    logic [31:0]   in_cnt_q, res_cnt_q, drop_cnt_q;
    logic          full, empty, push, drop, pop, issue, emit, timeout_hit;

    assign full        = (count_q == CW'(FIFO_DEPTH));
    assign empty       = (count_q == '0);
    assign push        = ifc.command_wr & ifc.command[63] & ~full;
    assign drop        = ifc.command_wr & ~push;
    assign timeout_hit = (timer_q == 8'(TIMEOUT - 1));
    assign count_d     = count_q + CW'(push) - CW'(pop);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (!empty) state_d = ISSUE;
            ISSUE:   if (ifc.bus_ack || timeout_hit) state_d = RESP;
            RESP:    if (!ifc.result_alf) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        pop   = 1'b0;
        issue = 1'b0;
        emit  = 1'b0;
        case (state_q)
            IDLE:    pop   = ~empty;
            ISSUE:   issue = 1'b1;
            RESP:    emit  = ~ifc.result_alf;
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (push) mem_q[wr_ptr_q] <= {ifc.command[63:61], ifc.command[59:0]};
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            cmd_q      <= '0;
            rdata_q    <= '0;
            ok_q       <= 1'b0;
            timer_q    <= '0;
            alf_q      <= 1'b0;
            res_wr_q   <= 1'b0;
            res_q      <= '0;
            in_cnt_q   <= '0;
            res_cnt_q  <= '0;
            drop_cnt_q <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
                cmd_q    <= mem_q[rd_ptr_q];
                timer_q  <= '0;
            end else if (issue) begin
                timer_q  <= timer_q + 8'd1;
            end
            // The returned data word is resolved at completion so RESP only has to pack it.
            if (issue && ifc.bus_ack) begin
                ok_q    <= 1'b1;
                rdata_q <= cmd_q[59] ? cmd_q[31:0] : ifc.bus_rdata;
            end else if (issue && timeout_hit) begin
                ok_q    <= 1'b0;
                rdata_q <= '0;
            end
            count_q  <= count_d;
            alf_q    <= (count_d >= CW'(ALF_LEVEL));
            res_wr_q <= emit;
            if (emit) res_q <= {cmd_q[62:60], ok_q, cmd_q[59:32], rdata_q};
            in_cnt_q   <= in_cnt_q + 32'(push);
            drop_cnt_q <= drop_cnt_q + 32'(drop);
            res_cnt_q  <= res_cnt_q + 32'(emit);
        end
    end

    assign ifc.command_alf = alf_q;
    assign ifc.result_wr   = res_wr_q;
    assign ifc.result      = res_q;
    assign ifc.bus_req     = issue;
    assign ifc.bus_rw      = cmd_q[59];
    assign ifc.bus_mdid    = cmd_q[58:52];
    assign ifc.bus_addr    = cmd_q[51:32];
    assign ifc.bus_wdata   = cmd_q[31:0];
    assign ifc.cmd_in_cnt  = in_cnt_q;
    assign ifc.result_cnt  = res_cnt_q;
    assign ifc.drop_cnt    = drop_cnt_q;
endmodule

// File: tb/tb_cmd_exec.sv
// Self-checking bench for cmd_exec: directed scenarios plus a randomized phase against a queue-based model.
// A bus responder and a result monitor run alongside the main stimulus thread.
module tb_cmd_exec;
    localparam int DEPTH = 8;
    localparam int ALF   = 6;
    localparam int TMO   = 255;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cmd_exec_if eif();

    cmd_exec #(.FIFO_DEPTH(DEPTH), .ALF_LEVEL(ALF), .TIMEOUT(TMO)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .ifc   (eif.slave)
    );

    int n_checks = 0;
    int n_errors = 0;
    int res_seen = 0;
    int exp_in   = 0;
    int exp_drop = 0;
    int ack_mode = -1;          // -1 random latency, -2 never ack, >=0 fixed latency
    bit resp_active = 1'b0;
    logic [63:0] exp_cmd_q [$];
    logic [63:0] exp_res_q [$];
    logic [31:0] rdata_q   [$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] exp_result(input logic [63:0] c, input bit ok, input logic [31:0] rd);
        logic [31:0] d;
        d = !ok ? 32'h0 : (c[59] ? c[31:0] : rd);
        return {c[63:61], ok, c[59:32], d};
    endfunction

    // Drives one command for one cycle; accept says whether the model expects FIFO room.
    task automatic send(input logic [63:0] c, input bit accept);
        eif.command_wr = 1'b1;
        eif.command    = c;
        if (c[63] && accept) begin
            exp_cmd_q.push_back(c);
            exp_in++;
        end else begin
            exp_drop++;
        end
        step();
        eif.command_wr = 1'b0;
    endtask

    task automatic wait_results(input int n, input int budget);
        int k;
        k = 0;
        while (res_seen < n && k < budget) begin
            step();
            k++;
        end
        chk("wait_results", 64'(res_seen), 64'(n));
    endtask

    // Result monitor
    initial begin
        forever begin
            step();
            if (!rst && eif.result_wr) begin
                res_seen++;
                chk("result_expected", 64'(exp_res_q.size() != 0), 64'd1);
                if (exp_res_q.size() != 0) chk("result_word", eif.result, exp_res_q.pop_front());
            end
        end
    end

    // Register-bus responder
    initial begin
        int lat, cyc;
        logic [63:0] c;
        logic [31:0] rd;
        bit to;
        lat = 0; cyc = 0; c = '0; rd = '0; to = 1'b0;
        eif.bus_ack   = 1'b0;
        eif.bus_rdata = '0;
        forever begin
            step();
            eif.bus_ack   = 1'b0;
            eif.bus_rdata = $urandom;
            if (rst) begin
                resp_active = 1'b0;
            end else if (eif.bus_req) begin
                if (!resp_active) begin
                    resp_active = 1'b1;
                    cyc = 0;
                    chk("bus_expected", 64'(exp_cmd_q.size() != 0), 64'd1);
                    c = '0;
                    if (exp_cmd_q.size() != 0) c = exp_cmd_q.pop_front();
                    chk("bus_fields", {4'h0, eif.bus_rw, eif.bus_mdid, eif.bus_addr, eif.bus_wdata},
                        {4'h0, c[59:0]});
                    to  = (ack_mode == -2);
                    lat = (ack_mode >= 0) ? ack_mode : $urandom_range(0, 4);
                    if (rdata_q.size() != 0) rd = rdata_q.pop_front();
                    else rd = $urandom;
                end
                cyc++;
                if (!to && cyc == lat + 1) begin
                    eif.bus_ack   = 1'b1;
                    eif.bus_rdata = rd;
                    exp_res_q.push_back(exp_result(c, 1'b1, rd));
                end
            end else begin
                if (resp_active) begin
                    resp_active = 1'b0;
                    if (to) begin
                        chk("timeout_req_cycles", 64'(cyc), 64'(TMO));
                        exp_res_q.push_back(exp_result(c, 1'b0, rd));
                    end
                end
                // Stray acks while no request is outstanding must be ignored.
                if (ack_mode == -1 && $urandom_range(0, 7) == 0) eif.bus_ack = 1'b1;
            end
        end
    end

    initial begin
        #900000;
        n_errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] c;
        int base, k;
        eif.command_wr = 1'b0;
        eif.command    = '0;
        eif.result_alf = 1'b0;
        repeat (3) step();
        chk("rst_bus_req",   eif.bus_req, 0);
        chk("rst_result_wr", eif.result_wr, 0);
        chk("rst_alf",       eif.command_alf, 0);
        chk("rst_result",    eif.result, 0);
        chk("rst_counters",  {eif.cmd_in_cnt, eif.result_cnt | eif.drop_cnt}, 0);
        rst = 1'b0;
        step();

        // Single write, ack three cycles into the request
        ack_mode = 3;
        send({3'b100, 1'b0, 1'b1, 7'd1, 20'd0, 32'h1234_5678}, 1'b1);
        chk("t1_req_not_yet", eif.bus_req, 0);
        step();
        chk("t1_req_latency", eif.bus_req, 1);
        wait_results(1, 50);
        chk("t1_result_cnt", eif.result_cnt, 1);

        // Three-command read frame with known read data
        ack_mode = -1;
        rdata_q.push_back(32'h11);
        rdata_q.push_back(32'h22);
        rdata_q.push_back(32'h33);
        send({3'b101, 1'b0, 1'b0, 7'd2, 20'h00010, 32'h0}, 1'b1);
        send({3'b111, 1'b0, 1'b0, 7'd2, 20'h00020, 32'h0}, 1'b1);
        send({3'b110, 1'b0, 1'b0, 7'd2, 20'h00030, 32'h0}, 1'b1);
        wait_results(4, 100);
        chk("t2_result_cnt", eif.result_cnt, 4);

        // Timeout
        ack_mode = -2;
        send({3'b100, 1'b0, 1'b0, 7'd5, 20'hABCDE, 32'hDEAD_BEEF}, 1'b1);
        wait_results(5, 400);

        // Burst of ten into an idle executor: one pops immediately, DEPTH more fit, the rest drop
        for (int i = 0; i < 10; i++) begin
            c = {3'b111, 1'b0, 1'b0, 7'(i), 20'(i * 4), 32'h0};
            send(c, i < DEPTH + 1);
        end
        repeat (3) step();
        chk("t4_alf_high",  eif.command_alf, 1);
        chk("t4_cmd_in",    eif.cmd_in_cnt, 64'(exp_in));
        chk("t4_drop",      eif.drop_cnt, 64'(exp_drop));
        chk("t4_drop_abs",  eif.drop_cnt, 1);
        wait_results(5 + DEPTH + 1, (DEPTH + 1) * (TMO + 10));
        chk("t4_alf_low",   eif.command_alf, 0);

        // Downstream almost-full holds the result in place
        ack_mode = -1;
        eif.result_alf = 1'b1;
        send({3'b100, 1'b0, 1'b0, 7'd9, 20'h00404, 32'h0}, 1'b1);
        k = 0;
        while (exp_res_q.size() == 0 && k < 30) begin
            step();
            k++;
        end
        base = res_seen;
        repeat (20) step();
        chk("t5_held", 64'(res_seen), 64'(base));
        eif.result_alf = 1'b0;
        step();
        chk("t5_emit", eif.result_wr, 1);
        wait_results(base + 1, 10);

        // Randomized traffic with invalid headers and random downstream stalls
        for (int n = 0; n < 200; n++) begin
            c = {$urandom, $urandom};
            c[63] = ($urandom_range(0, 7) != 0);
            if (c[63]) begin
                k = 0;
                while (exp_in - res_seen >= DEPTH && k < 2000) begin
                    eif.result_alf = 1'b0;
                    step();
                    k++;
                end
            end
            eif.result_alf = ($urandom_range(0, 4) == 0);
            send(c, 1'b1);
            repeat ($urandom_range(0, 2)) step();
        end
        eif.result_alf = 1'b0;
        wait_results(exp_in, 4000);
        repeat (3) step();
        chk("rand_cmd_in",     eif.cmd_in_cnt, 64'(exp_in));
        chk("rand_drop",       eif.drop_cnt, 64'(exp_drop));
        chk("rand_result_cnt", eif.result_cnt, 64'(exp_in));

        // Reset in the middle of a bus access
        ack_mode = -2;
        send({3'b100, 1'b0, 1'b1, 7'd3, 20'h00100, 32'hCAFE_F00D}, 1'b1);
        k = 0;
        while (!eif.bus_req && k < 50) begin
            step();
            k++;
        end
        chk("t6_req_seen", eif.bus_req, 1);
        repeat (3) step();
        #2 rst = 1'b1;
        #1;
        chk("t6_req_dropped", eif.bus_req, 0);
        chk("t6_result_wr",   eif.result_wr, 0);
        chk("t6_alf",         eif.command_alf, 0);
        chk("t6_counters",    {eif.cmd_in_cnt, eif.result_cnt | eif.drop_cnt}, 0);
        exp_cmd_q.delete();
        exp_res_q.delete();
        rdata_q.delete();
        exp_in = 0;
        exp_drop = 0;
        res_seen = 0;
        repeat (2) step();
        rst = 1'b0;
        repeat (10) step();
        chk("t6_no_result", eif.result_cnt, 0);
        ack_mode = -1;
        send({3'b100, 1'b0, 1'b0, 7'd4, 20'h00200, 32'h0}, 1'b1);
        wait_results(1, 50);
        chk("t6_recover_in", eif.cmd_in_cnt, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
